// File: rtl/prog_mem.sv
// prog_mem: program memory with a one-deep fetch holding stage, written-word flags and a load port.
// Optional build macro PROG_MEM_PARITY_EN adds a stored even-parity bit per word, checked on fetch.
module prog_mem #(
    parameter int DATA_W = 35,
    parameter int ADDR_W = 8,
    parameter int DEPTH = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err
);
    typedef enum logic {IDLE, VALID} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;
    logic              fetch_legal;
    logic              load_legal;
    logic              par_bad;
    logic              rd_err;
    logic [DATA_W-1:0] rd_data;

    assign fetch_legal = {1'b0, fetch_addr} < (ADDR_W+1)'(DEPTH);
    assign load_legal  = {1'b0, load_addr} < (ADDR_W+1)'(DEPTH);
    assign fetch_ack   = rst_n && fetch_req && (state == IDLE || fetch_ready);
    assign fetch_valid = state == VALID;

`ifdef PROG_MEM_PARITY_EN
    logic [DEPTH-1:0] parity;

    // parity bit is captured alongside the word so a later bit flip is detectable
    always_ff @(posedge clk) begin
        if (load_we && load_legal) parity[load_addr] <= ^load_data;
    end

    assign par_bad = fetch_legal && written[fetch_addr] && ((^mem[fetch_addr]) != parity[fetch_addr]);
`else
    assign par_bad = 1'b0;
`endif

    // word contents are not reset; the written flags mask stale data after reset
    always_ff @(posedge clk) begin
        if (load_we && load_legal) mem[load_addr] <= load_data;
    end

    // written flags and the out-of-range load pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written  <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= load_we && !load_legal;
            if (load_we && load_legal) written[load_addr] <= 1'b1;
        end
    end

    // read mux sees the pre-edge array, so a same-cycle load yields the old word
    always_comb begin
        rd_err  = !fetch_legal || par_bad;
        rd_data = (fetch_legal && written[fetch_addr] && !par_bad) ? mem[fetch_addr] : NOP_WORD;
    end

    // fetch holding stage: capture on ack, drain when the CPU takes the word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_data <= NOP_WORD;
            fetch_err  <= 1'b0;
        end else if (fetch_ack) begin
            state      <= VALID;
            fetch_data <= rd_data;
            fetch_err  <= rd_err;
        end else if (state == VALID && fetch_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: directed stimulus with a behavioural model checked every cycle plus literal spot checks.
module tb_prog_mem;
    localparam int DW = 35;
    localparam int AW = 8;
    localparam int DP = 200;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_req, fetch_ready, load_we;
    logic [AW-1:0] fetch_addr, load_addr;
    logic [DW-1:0] load_data;
    logic          fetch_ack, fetch_valid, fetch_err, load_err;
    logic [DW-1:0] fetch_data;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] m_mem [256];
    bit            m_wr [256];
    bit            m_valid = 1'b0;
    bit            m_err = 1'b0;
    bit            m_lerr = 1'b0;
    logic [DW-1:0] m_data = '0;

    prog_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .NOP_WORD('0)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
        .fetch_err(fetch_err), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // model: one held word; fetch reads memory before the same-cycle load lands
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_err   = 1'b0;
            m_lerr  = 1'b0;
            for (int i = 0; i < 256; i++) m_wr[i] = 1'b0;
        end else begin
            if (fetch_req && (!m_valid || fetch_ready)) begin
                m_valid = 1'b1;
                m_err   = int'(fetch_addr) >= DP;
                m_data  = (!m_err && m_wr[fetch_addr]) ? m_mem[fetch_addr] : '0;
            end else if (fetch_ready) begin
                m_valid = 1'b0;
            end
            m_lerr = load_we && int'(load_addr) >= DP;
            if (load_we && int'(load_addr) < DP) begin
                m_mem[load_addr] = load_data;
                m_wr[load_addr]  = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 64'(fetch_valid), 64'(m_valid));
            chk("ack", 64'(fetch_ack), 64'(rst_n && fetch_req && (!m_valid || fetch_ready)));
            chk("load_err", 64'(load_err), 64'(m_lerr));
            if (m_valid) begin
                chk("data", 64'(fetch_data), 64'(m_data));
                chk("err", 64'(fetch_err), 64'(m_err));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        fetch_req = 1'b1;
        fetch_ready = 1'b0;
        fetch_addr = '0;
        load_we = 1'b0;
        load_addr = '0;
        load_data = '0;
        step();
        step();
        chk("rst_valid", 64'(fetch_valid), 64'd0);
        chk("rst_data", 64'(fetch_data), 64'd0);
        chk("rst_err", 64'(fetch_err), 64'd0);
        chk("rst_lerr", 64'(load_err), 64'd0);
        chk("rst_ack", 64'(fetch_ack), 64'd0);
        fetch_req = 1'b0;
        rst_n = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            load_we = 1'b1;
            load_addr = AW'(i);
            load_data = DW'(2 * i + 1);
            step();
        end
        load_we = 1'b0;
        fetch_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fetch_req = 1'b1;
            fetch_addr = AW'(i);
            step();
            chk("seq_valid", 64'(fetch_valid), 64'd1);
            chk("seq_data", 64'(fetch_data), 64'(2 * i + 1));
        end
        fetch_req = 1'b0;
        step();
        chk("drain_valid", 64'(fetch_valid), 64'd0);
        fetch_req = 1'b1;
        fetch_addr = 8'd5;
        fetch_ready = 1'b0;
        step();
        fetch_addr = 8'd6;
        for (int i = 0; i < 4; i++) begin
            chk("stall_data", 64'(fetch_data), 64'd11);
            chk("stall_ack", 64'(fetch_ack), 64'd0);
            step();
        end
        fetch_ready = 1'b1;
        #1;
        chk("resume_ack", 64'(fetch_ack), 64'd1);
        step();
        chk("resume_data", 64'(fetch_data), 64'd13);
        fetch_addr = 8'd250;
        step();
        chk("oob_data", 64'(fetch_data), 64'd0);
        chk("oob_err", 64'(fetch_err), 64'd1);
        fetch_req = 1'b0;
        load_we = 1'b1;
        load_addr = 8'd250;
        load_data = DW'(7);
        step();
        chk("oob_lerr", 64'(load_err), 64'd1);
        load_we = 1'b0;
        step();
        chk("lerr_pulse", 64'(load_err), 64'd0);
        fetch_req = 1'b1;
        fetch_addr = 8'd150;
        step();
        chk("blank_data", 64'(fetch_data), 64'd0);
        chk("blank_err", 64'(fetch_err), 64'd0);
        load_we = 1'b1;
        load_addr = 8'd3;
        load_data = DW'(8'h55);
        fetch_addr = 8'd3;
        step();
        chk("same_old", 64'(fetch_data), 64'd7);
        load_we = 1'b0;
        step();
        chk("same_new", 64'(fetch_data), 64'h55);
        fetch_addr = 8'd1;
        step();
        chk("pre_rst_valid", 64'(fetch_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(fetch_valid), 64'd0);
        chk("async_data", 64'(fetch_data), 64'd0);
        fetch_req = 1'b0;
        step();
        rst_n = 1'b1;
        fetch_req = 1'b1;
        fetch_addr = 8'd0;
        step();
        chk("post_rst_valid", 64'(fetch_valid), 64'd1);
        chk("post_rst_data", 64'(fetch_data), 64'd0);
        chk("post_rst_err", 64'(fetch_err), 64'd0);
        fetch_req = 1'b0;
        load_we = 1'b1;
        load_addr = 8'd199;
        load_data = {3'b101, 32'hDEADBEEF};
        step();
        load_addr = 8'd200;
        load_data = DW'(9);
        fetch_req = 1'b1;
        fetch_addr = 8'd199;
        step();
        chk("last_data", 64'(fetch_data), 64'h5DEADBEEF);
        chk("last_err", 64'(fetch_err), 64'd0);
        chk("edge_lerr", 64'(load_err), 64'd1);
        load_we = 1'b0;
        fetch_addr = 8'd200;
        step();
        chk("edge_err", 64'(fetch_err), 64'd1);
        fetch_req = 1'b0;
        step();
`ifdef PROG_MEM_PARITY_EN
        load_we = 1'b1;
        load_addr = 8'd2;
        load_data = DW'(5);
        step();
        load_we = 1'b0;
        step();
        dut.mem[2] = dut.mem[2] ^ DW'(1);
        chk_en = 1'b0;
        fetch_req = 1'b1;
        fetch_addr = 8'd2;
        step();
        chk("par_data", 64'(fetch_data), 64'd0);
        chk("par_err", 64'(fetch_err), 64'd1);
        fetch_req = 1'b0;
        step();
        chk_en = 1'b1;
        step();
`endif
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
